uart_tx_framed: RTL and testbench

//   Parametrised single-clock UART transmitter with configurable framing and an input FIFO.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_framed_if.sv | 22 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx_framed.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, transmitter state encoding and
// baud divisor arithmetic.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Round-to-nearest clock cycles per bit; 64-bit intermediate avoids overflow.
    function automatic int uart_divisor(input int freq, input int baud);
        longint f;
        longint b;
        f = longint'(freq);
        b = longint'(baud);
        return int'((f + (b / 2)) / b);
    endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// Producer-side valid/ready handshake carrying one data word per transfer.
interface uart_tx_framed_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter producing a one-cycle tick every DIVISOR clocks;
// restart forces the count back to zero so a new frame starts on a full period.
module uart_baud_tick #(
    parameter int DIVISOR = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("uart_baud_tick: DIVISOR must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(DIVISOR - 1));
    assign tick   = at_end;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || at_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter with input FIFO and configurable framing (width, parity,
// stop bits, bit order); bit timing from a clock-enable tick.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int NATIVE_CLK_FREQUENCY = 50_000_000,
    parameter int BAUDRATE             = 9600,
    parameter int FRAME_DATA_LENGTH    = 8,
    parameter int PARITY_MODE          = PARITY_NONE,
    parameter int STOP_BITS            = 1,
    parameter int ENABLE_BIG_ENDIAN    = 0,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_framed_if.slave             in_if,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int DIVISOR = uart_divisor(NATIVE_CLK_FREQUENCY, BAUDRATE);
    localparam int DW      = FRAME_DATA_LENGTH;
    localparam int PTR_W   = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int IDX_W   = $clog2(FRAME_DATA_LENGTH);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("uart_tx_framed: clock/baud ratio gives DIVISOR below 2");
        end
        if (FRAME_DATA_LENGTH < 5 || FRAME_DATA_LENGTH > 9) begin : g_bad_length
            $error("uart_tx_framed: FRAME_DATA_LENGTH must be 5..9");
        end
        if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_ODD &&
            PARITY_MODE != PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_framed: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_framed: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_framed: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    // ---------------- input FIFO ----------------
    logic [DW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [DW-1:0]    head_word;

    assign fifo_full        = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty       = (level_q == '0);
    // Ready depends only on the level, so a same-cycle pop never frees a slot early.
    assign in_if.data_ready = !reset && !fifo_full;
    assign push             = in_if.data_valid && in_if.data_ready;
    assign head_word        = fifo_mem[rd_ptr_q];
    assign fifo_level       = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_if.data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // ---------------- framing FSM ----------------
    tx_state_e        state_q, state_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             parity_q, parity_d;
    logic             load;
    logic             baud_tick;
    logic             baud_restart;

    assign baud_restart = (state_q == TX_IDLE) && !fifo_empty;

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (baud_restart),
        .tick    (baud_tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        load     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    state_d = TX_DATA;
                    idx_d   = '0;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    shift_d = (ENABLE_BIG_ENDIAN != 0) ? (shift_q << 1) : (shift_q >> 1);
                    if (idx_q == IDX_W'(DW - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) begin
                    state_d = TX_STOP;
                    idx_d   = '0;
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when more data is queued.
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (load) begin
            state_d  = TX_START;
            shift_d  = head_word;
            idx_d    = '0;
            parity_d = (PARITY_MODE == PARITY_EVEN) ? (^head_word) : (~^head_word);
        end
    end

    assign pop = load;

    always_comb begin
        tx = 1'b1;
        case (state_q)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = (ENABLE_BIG_ENDIAN != 0) ? shift_q[DW-1] : shift_q[0];
            TX_PARITY: tx = parity_q;
            default:   tx = 1'b1;
        endcase
    end

    assign busy = (state_q != TX_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench: four framing configurations driven with random words and
// compared cycle by cycle against a bit-list frame model.
module tb_uart_tx_framed;
    import uart_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = 10;
    localparam int DEPTH  = 4;

    // Per-instance framing: 8N1, 8E1, 8O1, 7N2 MSB-first
    localparam int DLEN  [4] = '{8, 8, 8, 7};
    localparam int PAR   [4] = '{0, 2, 1, 0};
    localparam int STOPN [4] = '{1, 1, 1, 2};
    localparam int BIG   [4] = '{0, 0, 0, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [8:0] drv_data  [4];
    logic       drv_valid [4];
    logic       tx_w      [4];
    logic       busy_w    [4];
    logic       ready_w   [4];
    logic [2:0] level_w   [4];

    bit model_bits[$];

    uart_tx_framed_if #(.DATA_W(8)) if0 ();
    uart_tx_framed_if #(.DATA_W(8)) if1 ();
    uart_tx_framed_if #(.DATA_W(8)) if2 ();
    uart_tx_framed_if #(.DATA_W(7)) if3 ();

    assign if0.data = drv_data[0][7:0];
    assign if1.data = drv_data[1][7:0];
    assign if2.data = drv_data[2][7:0];
    assign if3.data = drv_data[3][6:0];
    assign if0.data_valid = drv_valid[0];
    assign if1.data_valid = drv_valid[1];
    assign if2.data_valid = drv_valid[2];
    assign if3.data_valid = drv_valid[3];
    assign ready_w[0] = if0.data_ready;
    assign ready_w[1] = if1.data_ready;
    assign ready_w[2] = if2.data_ready;
    assign ready_w[3] = if3.data_ready;

    uart_tx_framed #(.NATIVE_CLK_FREQUENCY(CLK_HZ), .BAUDRATE(BAUD), .FRAME_DATA_LENGTH(8),
        .PARITY_MODE(0), .STOP_BITS(1), .ENABLE_BIG_ENDIAN(0), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .reset(reset), .in_if(if0), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(level_w[0]));
    uart_tx_framed #(.NATIVE_CLK_FREQUENCY(CLK_HZ), .BAUDRATE(BAUD), .FRAME_DATA_LENGTH(8),
        .PARITY_MODE(2), .STOP_BITS(1), .ENABLE_BIG_ENDIAN(0), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .reset(reset), .in_if(if1), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(level_w[1]));
    uart_tx_framed #(.NATIVE_CLK_FREQUENCY(CLK_HZ), .BAUDRATE(BAUD), .FRAME_DATA_LENGTH(8),
        .PARITY_MODE(1), .STOP_BITS(1), .ENABLE_BIG_ENDIAN(0), .FIFO_DEPTH(DEPTH)) u2 (
        .clk(clk), .reset(reset), .in_if(if2), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(level_w[2]));
    uart_tx_framed #(.NATIVE_CLK_FREQUENCY(CLK_HZ), .BAUDRATE(BAUD), .FRAME_DATA_LENGTH(7),
        .PARITY_MODE(0), .STOP_BITS(2), .ENABLE_BIG_ENDIAN(1), .FIFO_DEPTH(DEPTH)) u3 (
        .clk(clk), .reset(reset), .in_if(if3), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_level(level_w[3]));

    // Line levels of one frame, one entry per bit period.
    function automatic void build_frame(input int u, input logic [8:0] w);
        int ones;
        int pos;
        ones = 0;
        model_bits.delete();
        model_bits.push_back(1'b0);
        for (int b = 0; b < DLEN[u]; b++) begin
            pos = (BIG[u] != 0) ? (DLEN[u] - 1 - b) : b;
            model_bits.push_back(w[pos]);
            ones += int'(w[b]);
        end
        if (PAR[u] == PARITY_EVEN) model_bits.push_back((ones % 2) == 1);
        if (PAR[u] == PARITY_ODD)  model_bits.push_back((ones % 2) == 0);
        for (int s = 0; s < STOPN[u]; s++) model_bits.push_back(1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int u, input logic [8:0] w);
        drv_data[u]  = w;
        drv_valid[u] = 1'b1;
        step();
        drv_valid[u] = 1'b0;
        drv_data[u]  = 9'($urandom);
    endtask

    // Called in the first cycle of the start bit; returns one cycle after the frame.
    task automatic expect_frame(input int u, input logic [8:0] w, input string name,
                                output logic busy_last);
        int   nb;
        int   bad_at;
        logic act;
        logic req;
        build_frame(u, w);
        nb = model_bits.size() * DIV;
        bad_at = -1;
        act = 1'b0;
        req = 1'b0;
        busy_last = 1'b0;
        for (int c = 0; c < nb; c++) begin
            if (bad_at < 0 && tx_w[u] !== model_bits[c / DIV]) begin
                bad_at = c;
                act = tx_w[u];
                req = model_bits[c / DIV];
            end
            busy_last = busy_w[u];
            step();
        end
        checks++;
        if (bad_at >= 0) begin
            failures++;
            $display("FAIL %s u%0d word=%h: tx at frame cycle %0d is %b, required %b",
                     name, u, w, bad_at, act, req);
        end else begin
            $display("frame %s u%0d word=%h cycles=%0d ok", name, u, w, nb);
        end
    endtask

    task automatic run_frame(input int u, input logic [8:0] w, input string name);
        logic bl;
        push(u, w);
        checks++;
        if (tx_w[u] !== 1'b1 || busy_w[u] !== 1'b1 || level_w[u] !== 3'd1) begin
            failures++;
            $display("FAIL %s_after_push u%0d: tx=%b busy=%b level=%0d, required tx=1 busy=1 level=1",
                     name, u, tx_w[u], busy_w[u], level_w[u]);
        end
        step();
        expect_frame(u, w, name, bl);
        checks++;
        if (tx_w[u] !== 1'b1 || busy_w[u] !== 1'b0 || bl !== 1'b1) begin
            failures++;
            $display("FAIL %s_end u%0d: tx=%b busy=%b busy_in_last_cycle=%b, required 1 0 1",
                     name, u, tx_w[u], busy_w[u], bl);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (tx_w[u] !== 1'b1 || busy_w[u] !== 1'b0 || level_w[u] !== 3'd0 || ready_w[u] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state u%0d: tx=%b busy=%b level=%0d ready=%b, required 1 0 0 0",
                         u, tx_w[u], busy_w[u], level_w[u], ready_w[u]);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ready_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: ready=%b, required 1", ready_w[0]);
        end
        $display("reset sequence done");
        step();
    endtask

    task automatic test_basic();
        run_frame(0, 9'h0A5, "8n1_a5");
        for (int i = 0; i < 3; i++) run_frame(0, 9'($urandom_range(0, 255)), "8n1_rand");
    endtask

    task automatic test_parity();
        run_frame(1, 9'h0A5, "8e1_a5");
        run_frame(2, 9'h0A5, "8o1_a5");
        run_frame(1, 9'($urandom_range(0, 255)), "8e1_rand");
        run_frame(2, 9'($urandom_range(0, 255)), "8o1_rand");
    endtask

    task automatic test_big_endian();
        run_frame(3, 9'h041, "7n2_msb_41");
        for (int i = 0; i < 2; i++) run_frame(3, 9'($urandom_range(0, 127)), "7n2_msb_rand");
    endtask

    // Six words offered continuously into a 4-deep FIFO; frames must follow back to back.
    task automatic test_back_to_back();
        logic [8:0] sb[$];
        logic [8:0] cur;
        logic       bl;
        int         fcyc;
        int         lvl;
        int         pushed;
        int         popped;
        build_frame(0, 9'd0);
        fcyc = model_bits.size() * DIV;
        lvl = 0;
        pushed = 0;
        popped = 0;
        bl = 1'b0;
        cur = 9'($urandom_range(0, 255));
        fork
            begin
                bit acc;
                bit pp;
                drv_data[0]  = cur;
                drv_valid[0] = 1'b1;
                for (int n = 1; n <= fcyc + 5; n++) begin
                    acc = (pushed < 6) && (lvl < DEPTH);
                    pp  = (n >= 2) && (((n - 2) % fcyc) == 0) && (lvl > 0);
                    step();
                    if (acc) begin
                        sb.push_back(cur);
                        pushed++;
                        $display("b2b push %0d word=%h at cycle %0d", pushed, cur, n);
                        cur = 9'($urandom_range(0, 255));
                        drv_data[0] = cur;
                        if (pushed == 6) drv_valid[0] = 1'b0;
                    end
                    if (pp) popped++;
                    lvl = lvl + int'(acc) - int'(pp);
                    checks++;
                    if (ready_w[0] !== (lvl != DEPTH) || level_w[0] !== 3'(lvl)) begin
                        failures++;
                        $display("FAIL b2b_fifo cycle %0d: ready=%b level=%0d, required ready=%b level=%0d",
                                 n, ready_w[0], level_w[0], (lvl != DEPTH), lvl);
                    end
                end
                drv_valid[0] = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                for (int k = 0; k < 6; k++) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b2b_scoreboard frame %0d: queue empty, required a pushed word", k);
                        break;
                    end
                    expect_frame(0, sb.pop_front(), "b2b", bl);
                end
                checks++;
                if (busy_w[0] !== 1'b0 || bl !== 1'b1 || tx_w[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_busy_fall: busy=%b busy_in_last_cycle=%b tx=%b, required 0 1 1",
                             busy_w[0], bl, tx_w[0]);
                end
            end
        join
        $display("b2b done pushed=%0d popped=%0d", pushed, popped);
    endtask

    task automatic test_reset_midframe();
        logic [8:0] w1;
        logic [8:0] w2;
        w1 = 9'($urandom_range(0, 255));
        w2 = 9'($urandom_range(0, 255));
        push(0, w1);
        push(0, w2);
        repeat (34) step();
        checks++;
        if (tx_w[0] !== w1[2]) begin
            failures++;
            $display("FAIL midframe_bit2: tx=%b, required %b", tx_w[0], w1[2]);
        end
        reset = 1'b1;
        step();
        checks++;
        if (tx_w[0] !== 1'b1 || level_w[0] !== 3'd0 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: tx=%b level=%0d busy=%b ready=%b, required 1 0 0 0",
                     tx_w[0], level_w[0], busy_w[0], ready_w[0]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ready_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL midframe_ready: ready=%b, required 1", ready_w[0]);
        end
        $display("reset during frame word=%h done", w1);
        run_frame(0, 9'($urandom_range(0, 255)), "after_reset");
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            drv_data[u]  = '0;
            drv_valid[u] = 1'b0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_big_endian();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
